m2p_indication_serializer: RTL and testbench

//  Parametrised method-to-pipe adapter for indication portals. Accepts up to NUM_METHODS

---
 rtl/m2p_indication_serializer_pkg.sv | 20 ++
 rtl/m2p_indication_serializer_if.sv | 24 ++
 rtl/m2p_indication_serializer_rr_arbiter.sv | 28 ++
 rtl/m2p_indication_serializer.sv | 133 +++++++++++++
 tb/tb_m2p_indication_serializer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/m2p_indication_serializer_pkg.sv
// Shared types and helpers for the method-to-pipe indication serializer.
// Holds the FSM state encoding, the header field widths and the beat-count helper.
package m2p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_e;

  localparam int PORTAL_W = 16;
  localparam int LEN_W    = 8;
  localparam int METHOD_W = 8;

  // Number of BEAT_W-wide payload beats needed to carry an ARG_W-bit argument.
  function automatic int nbeats(input int arg_w, input int beat_w);
    return (arg_w + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/m2p_indication_serializer_if.sv
// Bundles the method-call side and the enq pipe side of the serializer.
// master drives calls and pipe readiness; slave is the serializer itself.
interface m2p_indication_serializer_if #(
  parameter int NUM_METHODS = 4,
  parameter int ARG_W       = 64,
  parameter int BEAT_W      = 32
);
  logic [NUM_METHODS-1:0]       method_ena;
  logic [NUM_METHODS*ARG_W-1:0] method_v;
  logic [NUM_METHODS-1:0]       method_rdy;
  logic                         enq_ena;
  logic [BEAT_W-1:0]            enq_v;
  logic                         enq_rdy;

  modport master (
    output method_ena, method_v, enq_rdy,
    input  method_rdy, enq_ena, enq_v
  );

  modport slave (
    input  method_ena, method_v, enq_rdy,
    output method_rdy, enq_ena, enq_v
  );
endinterface

// File: rtl/m2p_indication_serializer_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
module rr_arbiter
  import m2p_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/m2p_indication_serializer.sv
// Buffers guarded indication method calls in one-entry holding registers and
// serialises them round-robin onto a narrow enq pipe as header + payload beats.
module m2p_indication_serializer
  import m2p_pkg::*;
#(
  parameter int NUM_METHODS = 4,
  parameter int ARG_W       = 64,
  parameter int BEAT_W      = 32,
  parameter int PORTAL_ID   = 5
) (
  input  logic                       CLK,
  input  logic                       nRST,
  m2p_indication_serializer_if.slave bus,
  output logic                       busy,
  output logic [31:0]                msg_count
);

  localparam int NB     = nbeats(ARG_W, BEAT_W);
  localparam int IDX_W  = $clog2(NUM_METHODS);
  localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PAD_W  = NB * BEAT_W;
  localparam logic [PORTAL_W-1:0] PID = PORTAL_W'(PORTAL_ID);
  localparam logic [LEN_W-1:0]    LEN = LEN_W'(NB);

  if (BEAT_W < 32) begin : g_chk_beat_w
    $error("BEAT_W must be at least 32");
  end
  if (NB > 255) begin : g_chk_nbeats
    $error("payload beat count must fit in 8 bits");
  end
  if (NUM_METHODS > 256) begin : g_chk_methods
    $error("NUM_METHODS must fit in the 8-bit method field");
  end

  state_e               state, state_d;
  logic [IDX_W-1:0]     sel, sel_d, rr_ptr, grant_idx;
  logic                 grant_vld;
  logic [BIDX_W-1:0]    beat, beat_d;
  logic                 last_acc;
  logic [NUM_METHODS-1:0] hold_valid, capture, release_mask;
  logic [ARG_W-1:0]     hold_arg [NUM_METHODS];
  logic [PAD_W-1:0]     arg_pad;
  logic [BEAT_W-1:0]    pay_beat [NB];
  logic [BEAT_W-1:0]    hdr_word;

  // A call is only captured into an empty slot; the slot in flight is frozen.
  assign capture      = bus.method_ena & ~hold_valid;
  assign release_mask = last_acc ? (NUM_METHODS'(1) << sel) : '0;

  rr_arbiter #(.N(NUM_METHODS)) u_arb (
    .req      (hold_valid),
    .ptr      (rr_ptr),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  always_comb begin
    state_d  = state;
    sel_d    = sel;
    beat_d   = beat;
    last_acc = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          sel_d   = grant_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        if (bus.enq_rdy) begin
          beat_d  = '0;
          state_d = PAY;
        end
      end
      PAY: begin
        if (bus.enq_rdy) begin
          if (beat == BIDX_W'(NB - 1)) begin
            last_acc = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      sel        <= '0;
      beat       <= '0;
      rr_ptr     <= '0;
      hold_valid <= '0;
      msg_count  <= '0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      beat       <= beat_d;
      hold_valid <= (hold_valid & ~release_mask) | capture;
      if (last_acc) begin
        rr_ptr    <= (sel == IDX_W'(NUM_METHODS - 1)) ? '0 : sel + 1'b1;
        msg_count <= msg_count + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_METHODS; i++) begin
      if (capture[i]) hold_arg[i] <= bus.method_v[i*ARG_W +: ARG_W];
    end
  end

  // Payload slices, least significant first; the last one is zero-padded on top.
  assign arg_pad = PAD_W'(hold_arg[sel]);
  for (genvar b = 0; b < NB; b++) begin : g_beat
    assign pay_beat[b] = arg_pad[b*BEAT_W +: BEAT_W];
  end

  assign hdr_word = BEAT_W'({PID, LEN, METHOD_W'(sel)});

  assign bus.enq_v      = (state == HDR) ? hdr_word :
                          (state == PAY) ? pay_beat[beat] : '0;
  assign bus.enq_ena    = (state != IDLE) & bus.enq_rdy;
  assign bus.method_rdy = ~hold_valid;
  assign busy           = (state != IDLE) | (|hold_valid);

  ena_while_full: assert property (
    @(posedge CLK) disable iff (!nRST) (bus.method_ena & hold_valid) == '0
  );

endmodule

// File: tb/tb_m2p_indication_serializer.sv
// Directed bench for the indication serializer: default 4x64/32 instance plus a
// 40-bit argument instance for payload padding.
module tb_m2p_indication_serializer;

  logic        CLK;
  logic        nRST;
  logic        busy, busy2;
  logic [31:0] msg_count, msg_count2;

  int n_cmp = 0;
  int n_bad = 0;

  m2p_indication_serializer_if #(.NUM_METHODS(4), .ARG_W(64), .BEAT_W(32)) bus ();
  m2p_indication_serializer_if #(.NUM_METHODS(4), .ARG_W(40), .BEAT_W(32)) bus2 ();

  m2p_indication_serializer #(.NUM_METHODS(4), .ARG_W(64), .BEAT_W(32), .PORTAL_ID(5)) u_dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .busy     (busy),
    .msg_count(msg_count)
  );

  m2p_indication_serializer #(.NUM_METHODS(4), .ARG_W(40), .BEAT_W(32), .PORTAL_ID(5)) u_pad (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus2),
    .busy     (busy2),
    .msg_count(msg_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a header on the default instance, then checks it and both payload beats.
  task automatic recv(input string tag, input logic [7:0] exp_id, input logic [63:0] exp_arg);
    int n;
    n = 0;
    while (!bus.enq_ena && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 64'(n < 20), 64'd1);
    chk({tag, "_hdr"}, 64'(bus.enq_v), 64'({16'd5, 8'd2, exp_id}));
    step();
    chk({tag, "_pay0_ena"}, 64'(bus.enq_ena), 64'd1);
    chk({tag, "_pay0"}, 64'(bus.enq_v), 64'(exp_arg[31:0]));
    step();
    chk({tag, "_pay1"}, 64'(bus.enq_v), 64'(exp_arg[63:32]));
    step();
  endtask

  int          issued [4];
  int          served [4];
  int          total, phase, got;
  logic [3:0]  mask;
  logic [31:0] base, held;
  logic [31:0] bp_exp [3];

  initial begin
    nRST            = 1'b0;
    bus.method_ena  = '0;
    bus.method_v    = '0;
    bus.enq_rdy     = 1'b1;
    bus2.method_ena = '0;
    bus2.method_v   = '0;
    bus2.enq_rdy    = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_rdy", 64'(bus.method_rdy), 64'hF);
    chk("rst_ena", 64'(bus.enq_ena), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(msg_count), 64'd0);
    nRST = 1'b1;
    step();

    // Single call on method 0
    bus.method_ena[0]   = 1'b1;
    bus.method_v[63:0]  = 64'h1122334455667788;
    step();
    bus.method_ena = '0;
    chk("single_rdy_low", 64'(bus.method_rdy[0]), 64'd0);
    chk("single_no_bypass", 64'(bus.enq_ena), 64'd0);
    step();
    chk("single_hdr_ena", 64'(bus.enq_ena), 64'd1);
    chk("single_hdr", 64'(bus.enq_v), 64'h00050200);
    step();
    chk("single_pay0", 64'(bus.enq_v), 64'h55667788);
    step();
    chk("single_pay1", 64'(bus.enq_v), 64'h11223344);
    step();
    chk("single_done_ena", 64'(bus.enq_ena), 64'd0);
    chk("single_count", 64'(msg_count), 64'd1);
    chk("single_rdy_back", 64'(bus.method_rdy[0]), 64'd1);

    // Round-robin: 1 and 3 together, then 1 again once released -> 1, 3, 1
    bus.method_ena        = 4'b1010;
    bus.method_v[127:64]  = 64'hA1A1A1A1_01010101;
    bus.method_v[255:192] = 64'hC3C3C3C3_03030303;
    step();
    bus.method_ena = '0;
    recv("rr_first", 8'd1, 64'hA1A1A1A1_01010101);
    chk("rr_rdy1_back", 64'(bus.method_rdy[1]), 64'd1);
    bus.method_ena[1]    = 1'b1;
    bus.method_v[127:64] = 64'hB1B1B1B1_11111111;
    step();
    bus.method_ena = '0;
    recv("rr_second", 8'd3, 64'hC3C3C3C3_03030303);
    recv("rr_third", 8'd1, 64'hB1B1B1B1_11111111);
    chk("rr_count", 64'(msg_count), 64'd4);

    // Backpressure: RDY 0101.. while method 2 is in flight
    bp_exp[0] = 32'h00050202;
    bp_exp[1] = 32'h0BADF00D;
    bp_exp[2] = 32'hDEADBEEF;
    bus.method_ena[2]      = 1'b1;
    bus.method_v[191:128]  = 64'hDEADBEEF_0BADF00D;
    step();
    bus.method_ena = '0;
    step();
    got  = 0;
    held = '0;
    for (int k = 0; k < 16 && got < 3; k++) begin
      bus.enq_rdy = k[0];
      #1;
      chk("bp_ena_follows_rdy", 64'(bus.enq_ena), 64'(bus.enq_rdy));
      if (!bus.enq_rdy) begin
        held = bus.enq_v;
      end else begin
        chk("bp_stable", 64'(bus.enq_v), 64'(held));
        chk("bp_beat", 64'(bus.enq_v), 64'(bp_exp[got]));
        got++;
      end
      step();
    end
    bus.enq_rdy = 1'b1;
    chk("bp_all_beats", 64'(got), 64'd3);
    chk("bp_count", 64'(msg_count), 64'd5);
    chk("bp_rdy2_back", 64'(bus.method_rdy[2]), 64'd1);

    // Random calls: every issued call must be served
    for (int i = 0; i < 4; i++) begin
      issued[i] = 0;
      served[i] = 0;
    end
    total = 0;
    phase = 0;
    base  = msg_count;
    for (int cyc = 0; cyc < 3000 && (total < 100 || busy); cyc++) begin
      if (bus.enq_ena) begin
        if (phase == 0) served[bus.enq_v[1:0]]++;
        phase = (phase == 2) ? 0 : phase + 1;
      end
      mask = '0;
      if (total < 100) begin
        mask = 4'($urandom) & bus.method_rdy;
        for (int i = 0; i < 4; i++) begin
          if (mask[i] && total < 100) begin
            issued[i]++;
            total++;
            bus.method_v[i*64 +: 64] = {$urandom, $urandom};
          end else begin
            mask[i] = 1'b0;
          end
        end
      end
      bus.method_ena = mask;
      step();
    end
    bus.method_ena = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand_served_m%0d", i), 64'(served[i]), 64'(issued[i]));
    end
    chk("rand_total", 64'(total), 64'd100);
    chk("rand_count", 64'(msg_count - base), 64'd100);
    chk("rand_idle", 64'(busy), 64'd0);

    // Reset in the middle of a message
    bus.method_ena[0]  = 1'b1;
    bus.method_v[63:0] = 64'hFEEDFACE_CAFEBABE;
    step();
    bus.method_ena = '0;
    step();
    chk("mid_hdr", 64'(bus.enq_v), 64'h00050200);
    step();
    chk("mid_in_pay", 64'(bus.enq_v), 64'hCAFEBABE);
    nRST = 1'b0;
    #1;
    chk("mid_async_ena", 64'(bus.enq_ena), 64'd0);
    step();
    chk("mid_rst_ena", 64'(bus.enq_ena), 64'd0);
    chk("mid_rst_rdy", 64'(bus.method_rdy), 64'hF);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(msg_count), 64'd0);
    nRST = 1'b1;
    step();
    bus.method_ena[0]  = 1'b1;
    bus.method_v[63:0] = 64'h0F0E0D0C_0B0A0908;
    step();
    bus.method_ena = '0;
    recv("fresh", 8'd0, 64'h0F0E0D0C_0B0A0908);
    chk("fresh_count", 64'(msg_count), 64'd1);

    // Padding on the 40-bit instance
    bus2.method_ena[0]   = 1'b1;
    bus2.method_v[39:0]  = 40'hAB_CDEF0123;
    step();
    bus2.method_ena = '0;
    step();
    chk("pad_hdr", 64'(bus2.enq_v), 64'h00050200);
    step();
    chk("pad_pay0", 64'(bus2.enq_v), 64'hCDEF0123);
    step();
    chk("pad_pay1", 64'(bus2.enq_v), 64'h000000AB);
    step();
    chk("pad_done_ena", 64'(bus2.enq_ena), 64'd0);
    chk("pad_count", 64'(msg_count2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
